// File: rtl/boruhatti_pkg.sv
// -----------------------------------------------------------------------------
// boruhatti_pkg
// Shared types and default parameter values for the pipeline controller
// (boruhatti_denetleyici) and its register scoreboard (boruhatti_skor_tablosu).
// -----------------------------------------------------------------------------
package boruhatti_pkg;

    localparam int STAGE_N_DEF      = 5;
    localparam int DEC_IDX_DEF      = 1;
    localparam int FLUSH_DEPTH_DEF  = 2;
    localparam int FLUSH_BUBBLE_DEF = 1;
    localparam int REG_N_DEF        = 32;
    localparam int PEND_W_DEF       = 2;
    localparam int REG_W_DEF        = $clog2(REG_N_DEF);

    // Architectural register index for the default register-file size.
    typedef logic [REG_W_DEF-1:0] reg_idx_t;

    // Redirect handling: idle, waiting for a downstream stall to clear,
    // or holding the flush for the remaining bubble cycles.
    typedef enum logic [1:0] {
        FL_IDLE   = 2'd0,
        FL_PEND   = 2'd1,
        FL_BUBBLE = 2'd2
    } flush_state_t;

endpackage

// File: rtl/boruhatti_skor_tablosu.sv
// -----------------------------------------------------------------------------
// boruhatti_skor_tablosu
// Register scoreboard: one saturating-free in-flight write counter per
// architectural register (register 0 is never tracked), RAW hazard detection
// for the two source operands and the "rd counter saturated" indication.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_issue                   decode holds an instruction that wants to issue
//   i_issue_acc               the issue is accepted this cycle
//   i_issue_wr, i_issue_rd    issuing instruction writes rd
//   i_rs1_en/i_rs1, i_rs2_en/i_rs2  source operands read by the issue
//   i_retire, i_retire_rd     writeback commits a register write
//   o_hazard                  a read source still has a write in flight
//   o_full                    the rd counter cannot take another write
// -----------------------------------------------------------------------------
module boruhatti_skor_tablosu
    import boruhatti_pkg::*;
#(
    parameter  int REG_N  = REG_N_DEF,
    parameter  int PEND_W = PEND_W_DEF,
    localparam int REG_W  = $clog2(REG_N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_issue,
    input  logic             i_issue_acc,
    input  logic             i_issue_wr,
    input  logic [REG_W-1:0] i_issue_rd,
    input  logic             i_rs1_en,
    input  logic [REG_W-1:0] i_rs1,
    input  logic             i_rs2_en,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_retire,
    input  logic [REG_W-1:0] i_retire_rd,
    output logic             o_hazard,
    output logic             o_full
);

    logic [PEND_W-1:0] w_cnt [REG_N];
    logic [PEND_W-1:0] w_cnt_rs1;
    logic [PEND_W-1:0] w_cnt_rs2;
    logic [PEND_W-1:0] w_cnt_rd;
    logic              w_rs1_busy;
    logic              w_rs2_busy;

    // Register 0 is hard-wired, so it never shows as busy.
    assign w_cnt[0] = '0;

    for (genvar r = 1; r < REG_N; r++) begin : g_cnt
        logic [PEND_W-1:0] r_cnt;
        logic              w_inc;
        logic              w_dec;

        assign w_inc = i_issue_acc & i_issue_wr & (i_issue_rd == REG_W'(r));
        // A retire against an empty counter is a no-op rather than a wrap.
        assign w_dec = i_retire & (i_retire_rd == REG_W'(r)) & (r_cnt != '0);

        // NOTE: these counters look like a small memory but must be reset:
        // a stale non-zero count after reset would stall issue forever.
        // Sequential state is always written with <= so every flop samples
        // the pre-edge value of its neighbours.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + PEND_W'(1);
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - PEND_W'(1);
            end
        end

        assign w_cnt[r] = r_cnt;
    end

    assign w_cnt_rs1 = w_cnt[i_rs1];
    assign w_cnt_rs2 = w_cnt[i_rs2];
    assign w_cnt_rd  = w_cnt[i_issue_rd];

    // The last outstanding write retiring this cycle is forwarded through the
    // register file, so it no longer counts as busy.
    assign w_rs1_busy = (i_rs1 != '0) && (w_cnt_rs1 != '0) &&
                        !(i_retire && (i_retire_rd == i_rs1) && (w_cnt_rs1 == PEND_W'(1)));
    assign w_rs2_busy = (i_rs2 != '0) && (w_cnt_rs2 != '0) &&
                        !(i_retire && (i_retire_rd == i_rs2) && (w_cnt_rs2 == PEND_W'(1)));

    assign o_hazard = i_issue & ((i_rs1_en & w_rs1_busy) | (i_rs2_en & w_rs2_busy));

    // A same-cycle retire to rd frees a slot, so the issue may proceed.
    assign o_full = i_issue & i_issue_wr & (i_issue_rd != '0) & (&w_cnt_rd) &
                    !(i_retire && (i_retire_rd == i_issue_rd));

endmodule

// File: rtl/boruhatti_denetleyici.sv
// -----------------------------------------------------------------------------
// boruhatti_denetleyici
// Stall/flush controller for an N-stage in-order pipeline with a register
// scoreboard at the issue (decode) boundary and deferred multi-cycle flushes.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   stall_req_i[STAGE_N]      per-stage stall requests
//   flush_req_i               redirect request
//   issue_*                   issuing instruction (rd write, rs1/rs2 reads)
//   retire_i, retire_rd_i     writeback commit
//   stall_o, flush_o          per-stage hold / bubble-load
//   issue_ready_o             issue accepted this cycle
//   hazard_o, sb_full_o       RAW hazard / rd counter saturated
//   stall_cyc_o, flush_cnt_o  performance counters
//
// Build option: BORUHATTI_SAYAC_EN builds the two 32-bit performance
// counters; without it both ports read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module boruhatti_denetleyici
    import boruhatti_pkg::*;
#(
    parameter  int STAGE_N      = STAGE_N_DEF,
    parameter  int DEC_IDX      = DEC_IDX_DEF,
    parameter  int FLUSH_DEPTH  = FLUSH_DEPTH_DEF,
    parameter  int FLUSH_BUBBLE = FLUSH_BUBBLE_DEF,
    parameter  int REG_N        = REG_N_DEF,
    parameter  int PEND_W       = PEND_W_DEF,
    localparam int REG_W        = $clog2(REG_N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [STAGE_N-1:0] stall_req_i,
    input  logic               flush_req_i,
    input  logic               issue_i,
    input  logic               issue_wr_i,
    input  logic [REG_W-1:0]   issue_rd_i,
    input  logic               issue_rs1_en_i,
    input  logic               issue_rs2_en_i,
    input  logic [REG_W-1:0]   issue_rs1_i,
    input  logic [REG_W-1:0]   issue_rs2_i,
    input  logic               retire_i,
    input  logic [REG_W-1:0]   retire_rd_i,
    output logic [STAGE_N-1:0] stall_o,
    output logic [STAGE_N-1:0] flush_o,
    output logic               issue_ready_o,
    output logic               hazard_o,
    output logic               sb_full_o,
    output logic [31:0]        stall_cyc_o,
    output logic [31:0]        flush_cnt_o
);

    localparam int                 BUB_W      = (FLUSH_BUBBLE > 1) ? $clog2(FLUSH_BUBBLE) : 1;
    localparam logic [BUB_W-1:0]   BUB_RELOAD = BUB_W'(FLUSH_BUBBLE - 1);

    flush_state_t       r_state;
    flush_state_t       w_state_nxt;
    logic [BUB_W-1:0]   r_bub;
    logic [BUB_W-1:0]   w_bub_nxt;
    logic               w_flush_apply;
    logic               w_flush_act;
    logic               w_blocked;
    logic [STAGE_N-1:0] w_stall_chain;
    logic [STAGE_N-1:0] w_flush;
    logic               w_hazard;
    logic               w_full;
    logic               w_issue_acc;

    assign w_issue_acc = issue_i & issue_ready_o;

    boruhatti_skor_tablosu #(
        .REG_N  (REG_N),
        .PEND_W (PEND_W)
    ) u_skor (
        .i_clk       (clk_i),
        .i_rst_n     (rst_i),
        .i_issue     (issue_i),
        .i_issue_acc (w_issue_acc),
        .i_issue_wr  (issue_wr_i),
        .i_issue_rd  (issue_rd_i),
        .i_rs1_en    (issue_rs1_en_i),
        .i_rs1       (issue_rs1_i),
        .i_rs2_en    (issue_rs2_en_i),
        .i_rs2       (issue_rs2_i),
        .i_retire    (retire_i),
        .i_retire_rd (retire_rd_i),
        .o_hazard    (w_hazard),
        .o_full      (w_full)
    );

    // A stall request holds its own stage and everything upstream of it.
    // Scoreboard stalls hold decode and fetch only. Any downstream stall at
    // or past the flushed region blocks a redirect.
    // NOTE: blocking assignments are correct in always_comb; every output is
    // given a default first so no latch is inferred.
    always_comb begin : p_stall
        logic v_acc;
        v_acc         = 1'b0;
        w_stall_chain = '0;
        w_blocked     = 1'b0;
        for (int i = STAGE_N - 1; i >= 0; i--) begin
            v_acc            = v_acc | stall_req_i[i];
            w_stall_chain[i] = v_acc;
            if (i <= DEC_IDX) begin
                w_stall_chain[i] = v_acc | w_hazard | w_full;
            end
            if (i >= FLUSH_DEPTH) begin
                w_blocked = w_blocked | stall_req_i[i];
            end
        end
    end

    always_comb begin : p_fsm
        w_state_nxt   = r_state;
        w_bub_nxt     = r_bub;
        w_flush_apply = 1'b0;
        w_flush_act   = 1'b0;
        unique case (r_state)
            FL_IDLE: begin
                if (flush_req_i) begin
                    if (w_blocked) begin
                        w_state_nxt = FL_PEND;
                    end else begin
                        w_flush_apply = 1'b1;
                    end
                end
            end
            FL_PEND: begin
                if (!w_blocked) begin
                    w_flush_apply = 1'b1;
                end
            end
            FL_BUBBLE: begin
                w_flush_act = 1'b1;
                if (flush_req_i) begin
                    w_bub_nxt = BUB_RELOAD;
                end else if (r_bub <= BUB_W'(1)) begin
                    w_bub_nxt   = '0;
                    w_state_nxt = FL_IDLE;
                end else begin
                    w_bub_nxt = r_bub - BUB_W'(1);
                end
            end
            default: w_state_nxt = FL_IDLE;
        endcase

        // First flush cycle is combinational; the rest come from FL_BUBBLE.
        if (w_flush_apply) begin
            w_flush_act = 1'b1;
            if (FLUSH_BUBBLE > 1) begin
                w_state_nxt = FL_BUBBLE;
                w_bub_nxt   = BUB_RELOAD;
            end else begin
                w_state_nxt = FL_IDLE;
            end
        end
    end

    always_comb begin : p_flush_mask
        w_flush = '0;
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
            w_flush[i] = w_flush_act;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= FL_IDLE;
            r_bub   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
        end
    end

    // Outputs are forced low while reset is held. A flushed stage loads a
    // bubble, so its hold is dropped.
    assign flush_o       = rst_i ? w_flush : '0;
    assign stall_o       = rst_i ? (w_stall_chain & ~w_flush) : '0;
    assign hazard_o      = rst_i & w_hazard;
    assign sb_full_o     = rst_i & w_full;
    assign issue_ready_o = rst_i & !stall_o[DEC_IDX] & !flush_o[DEC_IDX];

`ifdef BORUHATTI_SAYAC_EN
    logic [31:0] r_stall_cyc;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cyc <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_o[DEC_IDX]) begin
                r_stall_cyc <= r_stall_cyc + 32'd1;
            end
            if (w_flush_apply) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cyc_o = r_stall_cyc;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cyc_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_boruhatti_denetleyici.sv
// -----------------------------------------------------------------------------
// tb_boruhatti_denetleyici
// Self-checking bench for boruhatti_denetleyici (STAGE_N=5, DEC_IDX=1,
// FLUSH_DEPTH=2, FLUSH_BUBBLE=2, REG_N=32, PEND_W=2). Each step drives the
// inputs, pushes the expected output vector {stall_o, flush_o, issue_ready_o,
// hazard_o, sb_full_o} onto a scoreboard queue, and pops/compares it at the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_boruhatti_denetleyici;
    import boruhatti_pkg::*;

    localparam int STAGE_N      = 5;
    localparam int DEC_IDX      = 1;
    localparam int FLUSH_DEPTH  = 2;
    localparam int FLUSH_BUBBLE = 2;
    localparam int REG_N        = 32;
    localparam int PEND_W       = 2;
    localparam int REG_W        = $clog2(REG_N);

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [STAGE_N-1:0] stall_req_i;
    logic               flush_req_i;
    logic               issue_i;
    logic               issue_wr_i;
    logic [REG_W-1:0]   issue_rd_i;
    logic               issue_rs1_en_i;
    logic               issue_rs2_en_i;
    logic [REG_W-1:0]   issue_rs1_i;
    logic [REG_W-1:0]   issue_rs2_i;
    logic               retire_i;
    logic [REG_W-1:0]   retire_rd_i;
    logic [STAGE_N-1:0] stall_o;
    logic [STAGE_N-1:0] flush_o;
    logic               issue_ready_o;
    logic               hazard_o;
    logic               sb_full_o;
    logic [31:0]        stall_cyc_o;
    logic [31:0]        flush_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] exp_q[$];
    string       name_q[$];

    // sr, fr, iss, wr, rd, e1, s1, e2, s2, ret, rrd, expected vector
    typedef struct {
        int          sr;
        int          fr;
        int          iss;
        int          wr;
        int          rd;
        int          e1;
        int          s1;
        int          e2;
        int          s2;
        int          ret;
        int          rrd;
        logic [12:0] ex;
    } step_t;

    boruhatti_denetleyici #(
        .STAGE_N      (STAGE_N),
        .DEC_IDX      (DEC_IDX),
        .FLUSH_DEPTH  (FLUSH_DEPTH),
        .FLUSH_BUBBLE (FLUSH_BUBBLE),
        .REG_N        (REG_N),
        .PEND_W       (PEND_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_req_i    (stall_req_i),
        .flush_req_i    (flush_req_i),
        .issue_i        (issue_i),
        .issue_wr_i     (issue_wr_i),
        .issue_rd_i     (issue_rd_i),
        .issue_rs1_en_i (issue_rs1_en_i),
        .issue_rs2_en_i (issue_rs2_en_i),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_i    (issue_rs2_i),
        .retire_i       (retire_i),
        .retire_rd_i    (retire_rd_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .issue_ready_o  (issue_ready_o),
        .hazard_o       (hazard_o),
        .sb_full_o      (sb_full_o),
        .stall_cyc_o    (stall_cyc_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic apply(input step_t s);
        stall_req_i    = STAGE_N'(s.sr);
        flush_req_i    = (s.fr != 0);
        issue_i        = (s.iss != 0);
        issue_wr_i     = (s.wr != 0);
        issue_rd_i     = REG_W'(s.rd);
        issue_rs1_en_i = (s.e1 != 0);
        issue_rs1_i    = REG_W'(s.s1);
        issue_rs2_en_i = (s.e2 != 0);
        issue_rs2_i    = REG_W'(s.s2);
        retire_i       = (s.ret != 0);
        retire_rd_i    = REG_W'(s.rrd);
    endtask

    task automatic test_reset();
        logic [12:0] got, want;
        string       nm;
        #2 rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            stall_req_i    = STAGE_N'($urandom);
            flush_req_i    = 1'($urandom);
            issue_i        = 1'($urandom);
            issue_wr_i     = 1'($urandom);
            issue_rd_i     = REG_W'($urandom);
            issue_rs1_en_i = 1'($urandom);
            issue_rs1_i    = REG_W'($urandom);
            issue_rs2_en_i = 1'($urandom);
            issue_rs2_i    = REG_W'($urandom);
            retire_i       = 1'($urandom);
            retire_rd_i    = REG_W'($urandom);
            exp_q.push_back(13'b0);
            name_q.push_back($sformatf("reset_held[%0d]", k));
            @(negedge clk_i);
            got  = {stall_o, flush_o, issue_ready_o, hazard_o, sb_full_o};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", nm, got, want);
            end
            n_tests++;
            if ({stall_cyc_o, flush_cnt_o} !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_counters[%0d]: got %0d/%0d want 0/0", k, stall_cyc_o, flush_cnt_o);
            end
        end
        @(posedge clk_i); #1;
        apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b0});
        rst_i = 1'b1;
        exp_q.push_back(13'b00000_00000_1_0_0);
        name_q.push_back("reset_released");
        @(negedge clk_i);
        got  = {stall_o, flush_o, issue_ready_o, hazard_o, sb_full_o};
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_stall_prop();
        step_t       tbl[$];
        logic [12:0] got, want;
        string       nm;
        tbl.push_back('{'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b01111_00000_0_0_0});
        tbl.push_back('{'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00001_00000_1_0_0});
        tbl.push_back('{'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b11111_00000_0_0_0});
        tbl.push_back('{'b00010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00011_00000_0_0_0});
        tbl.push_back('{'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00111_00000_0_0_0});
        tbl.push_back('{'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});
        foreach (tbl[k]) begin
            apply(tbl[k]);
            exp_q.push_back(tbl[k].ex);
            name_q.push_back($sformatf("stall_prop[%0d]", k));
            @(negedge clk_i);
            got  = {stall_o, flush_o, issue_ready_o, hazard_o, sb_full_o};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", nm, got, want);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_raw_hazard();
        step_t       tbl[$];
        logic [12:0] got, want;
        string       nm;
        tbl.push_back('{0,       0, 1, 1,  5, 0,  0, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // write r5
        tbl.push_back('{0,       0, 1, 0,  0, 1,  5, 0, 0, 0,  0, 13'b00011_00000_0_1_0}); // read r5: hazard
        tbl.push_back('{0,       0, 1, 0,  0, 1,  5, 0, 0, 1,  5, 13'b00000_00000_1_0_0}); // retire bypass
        tbl.push_back('{0,       0, 1, 0,  0, 1,  5, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // r5 now free
        tbl.push_back('{0,       0, 1, 1,  9, 1,  5, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // write r9
        tbl.push_back('{0,       0, 1, 0,  0, 0,  0, 1, 9, 0,  0, 13'b00011_00000_0_1_0}); // rs2 hazard
        tbl.push_back('{0,       0, 1, 0,  0, 0,  9, 0, 9, 0,  0, 13'b00000_00000_1_0_0}); // not read
        tbl.push_back('{0,       0, 0, 0,  0, 0,  0, 0, 0, 1,  9, 13'b00000_00000_1_0_0}); // retire r9
        tbl.push_back('{0,       0, 1, 0,  0, 0,  0, 1, 9, 0,  0, 13'b00000_00000_1_0_0}); // r9 free
        tbl.push_back('{0,       0, 1, 1,  0, 0,  0, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // write r0
        tbl.push_back('{0,       0, 1, 0,  0, 1,  0, 1, 0, 0,  0, 13'b00000_00000_1_0_0}); // r0 never busy
        tbl.push_back('{0,       0, 1, 1, 12, 0,  0, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // write r12
        tbl.push_back('{'b01000, 0, 1, 0,  0, 1, 12, 0, 0, 0,  0, 13'b01111_00000_0_1_0}); // hazard + stall
        tbl.push_back('{0,       0, 0, 0,  0, 0,  0, 0, 0, 1, 12, 13'b00000_00000_1_0_0}); // retire r12
        tbl.push_back('{0,       0, 1, 1, 14, 0,  0, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // r14 cnt 1
        tbl.push_back('{0,       0, 1, 1, 14, 0,  0, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // r14 cnt 2
        tbl.push_back('{0,       0, 1, 0,  0, 1, 14, 0, 0, 1, 14, 13'b00011_00000_0_1_0}); // cnt 2: no bypass
        tbl.push_back('{0,       0, 1, 0,  0, 1, 14, 0, 0, 1, 14, 13'b00000_00000_1_0_0}); // cnt 1: bypass
        tbl.push_back('{0,       0, 1, 0,  0, 1, 14, 0, 0, 0,  0, 13'b00000_00000_1_0_0}); // r14 free
        foreach (tbl[k]) begin
            apply(tbl[k]);
            exp_q.push_back(tbl[k].ex);
            name_q.push_back($sformatf("raw_hazard[%0d]", k));
            @(negedge clk_i);
            got  = {stall_o, flush_o, issue_ready_o, hazard_o, sb_full_o};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", nm, got, want);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_saturation();
        step_t       tbl[$];
        logic [12:0] got, want;
        string       nm;
        for (int k = 0; k < 3; k++)
            tbl.push_back('{0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});   // cnt 1..3
        tbl.push_back('{0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 13'b00011_00000_0_0_1});       // full
        tbl.push_back('{0, 0, 1, 1, 7, 0, 0, 0, 0, 1, 7, 13'b00000_00000_1_0_0});       // retire frees slot
        tbl.push_back('{0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 13'b00011_00000_0_0_1});       // still 3
        tbl.push_back('{0, 0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 13'b00011_00000_0_1_0});       // read r7
        for (int k = 0; k < 4; k++)
            tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 13'b00000_00000_1_0_0});   // drain, then extra
        tbl.push_back('{0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});       // cnt 1
        tbl.push_back('{0, 0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 13'b00011_00000_0_1_0});       // busy at 1
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 13'b00000_00000_1_0_0});       // clean up
        foreach (tbl[k]) begin
            apply(tbl[k]);
            exp_q.push_back(tbl[k].ex);
            name_q.push_back($sformatf("saturation[%0d]", k));
            @(negedge clk_i);
            got  = {stall_o, flush_o, issue_ready_o, hazard_o, sb_full_o};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", nm, got, want);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_deferred_flush();
        step_t       tbl[$];
        logic [12:0] got, want;
        string       nm;
        tbl.push_back('{'b01000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b01111_00000_0_0_0}); // blocked
        tbl.push_back('{'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b01111_00000_0_0_0});
        tbl.push_back('{'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b01111_00000_0_0_0});
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0}); // released
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0}); // bubble
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});
        tbl.push_back('{'b00001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0}); // upstream stall
        tbl.push_back('{'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00100_00011_0_0_0}); // flush wins
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});
        tbl.push_back('{0,       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0});
        tbl.push_back('{0,       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0}); // reload
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0});
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});
        tbl.push_back('{'b00100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00111_00000_0_0_0}); // blocked at 2
        tbl.push_back('{'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00111_00000_0_0_0});
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0});
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0});
        tbl.push_back('{0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});
        foreach (tbl[k]) begin
            apply(tbl[k]);
            exp_q.push_back(tbl[k].ex);
            name_q.push_back($sformatf("deferred_flush[%0d]", k));
            @(negedge clk_i);
            got  = {stall_o, flush_o, issue_ready_o, hazard_o, sb_full_o};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", nm, got, want);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_counters();
        step_t       tbl[$];
        logic [12:0] got, want;
        string       nm;
        int          want_sc;
        int          want_fc;
`ifdef BORUHATTI_SAYAC_EN
        want_sc = 4;
        want_fc = 2;
`else
        want_sc = 0;
        want_fc = 0;
`endif
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        n_tests++;
        if ({stall_cyc_o, flush_cnt_o} !== 64'd0) begin
            n_fail++;
            $display("FAIL counters_after_reset: got %0d/%0d want 0/0", stall_cyc_o, flush_cnt_o);
        end
        tbl.push_back('{0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});
        for (int k = 0; k < 4; k++)
            tbl.push_back('{0, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 13'b00011_00000_0_1_0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 13'b00000_00000_1_0_0});
        for (int k = 0; k < 2; k++) begin
            tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0});
            tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00011_0_0_0});
            tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b00000_00000_1_0_0});
        end
        foreach (tbl[k]) begin
            apply(tbl[k]);
            exp_q.push_back(tbl[k].ex);
            name_q.push_back($sformatf("counters_seq[%0d]", k));
            @(negedge clk_i);
            got  = {stall_o, flush_o, issue_ready_o, hazard_o, sb_full_o};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", nm, got, want);
            end
            @(posedge clk_i); #1;
        end
        n_tests++;
        if (stall_cyc_o !== 32'(want_sc)) begin
            n_fail++;
            $display("FAIL stall_cyc: got %0d want %0d", stall_cyc_o, want_sc);
        end
        n_tests++;
        if (flush_cnt_o !== 32'(want_fc)) begin
            n_fail++;
            $display("FAIL flush_cnt: got %0d want %0d", flush_cnt_o, want_fc);
        end
    endtask

    initial begin
        apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b0});
        test_reset();
        test_stall_prop();
        test_raw_hazard();
        test_saturation();
        test_deferred_flush();
        test_counters();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/boruhatti_denetleyici.md
# boruhatti_denetleyici

Parametrised successor to the core's fixed five-stage pipeline controller. It generates per-stage stall and flush signals for an N-stage in-order pipeline. It adds a register scoreboard with per-register in-flight write counters for RAW hazard detection at the issue boundary. Flush requests that arrive while a downstream stall is active are deferred until the stall clears, and each flush produces a multi-cycle bubble. It sits beside getir/coz/yurut/bellek/geri_yaz and replaces the purely combinational controller.

## Interface
Parameters:
- STAGE_N, 5: number of pipeline stages; index 0 is fetch.
- DEC_IDX, 1: index of the issuing (decode) stage; must be less than STAGE_N-1.
- FLUSH_DEPTH, 2: stages 0..FLUSH_DEPTH-1 are flushed on a redirect; must satisfy FLUSH_DEPTH ≤ DEC_IDX+1.
- FLUSH_BUBBLE, 1: number of cycles flush_o stays asserted per redirect; must be ≥1.
- REG_N, 32: number of architectural registers; register 0 is never tracked.
- PEND_W, 2: width of each per-register in-flight write counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_req_i  in  STAGE_N  stall request from each stage (yurut multicycle, bellek wait, ...).
- flush_req_i  in  1  redirect request (misprediction or jal/jalr).
- issue_i  in  1  decode holds a valid instruction that wants to issue.
- issue_wr_i  in  1  the issuing instruction writes rd.
- issue_rd_i  in  $clog2(REG_N)  destination register.
- issue_rs1_en_i, issue_rs2_en_i  in  1  source register is read.
- issue_rs1_i, issue_rs2_i  in  $clog2(REG_N)  source registers.
- retire_i  in  1  writeback commits a register write.
- retire_rd_i  in  $clog2(REG_N)  register being written back.
- stall_o  out  STAGE_N  hold the stage register.
- flush_o  out  STAGE_N  load a bubble into the stage register.
- issue_ready_o  out  1  the issue is accepted this cycle.
- hazard_o  out  1  RAW hazard detected.
- sb_full_o  out  1  the rd counter is saturated.
- stall_cyc_o  out  32  count of cycles with a decode stall.
- flush_cnt_o  out  32  count of applied flushes.

## Operation
- Scoreboard: one counter per register 1..REG_N-1, PEND_W bits wide.
  - An accepted issue is issue_i & issue_ready_o.
  - An accepted issue with issue_wr_i and rd≠0 increments cnt[rd].
  - retire_i with rd≠0 decrements cnt[rd].
  - An increment and a decrement to the same register in the same cycle leave the counter unchanged.
  - A retire when the counter is already 0 is ignored.
- hazard_o = issue_i & ((rs1_en & rs1≠0 & busy(rs1)) | (same for rs2)).
  - busy(r) = cnt[r]≠0 & !(retire_i & retire_rd_i==r & cnt[r]==1). A retire in the current cycle bypasses through the register file.
- sb_full_o = issue_i & issue_wr_i & rd≠0 & cnt[rd] is all-ones & !(retire_i & retire_rd_i==rd).
- Stall propagation: stall_o[i] = OR of stall_req_i[j] for j≥i.
  - hazard_o and sb_full_o are additionally OR-ed into stall_o[0..DEC_IDX].
- issue_ready_o = !stall_o[DEC_IDX] & !flush_o[DEC_IDX].
- Flush blocking: a flush is blocked while any stall_req_i[j] with j≥FLUSH_DEPTH is high.
- Flush states:
  - IDLE: on an unblocked flush_req_i, assert flush_o[0..FLUSH_DEPTH-1] in the same cycle. Go to BUBBLE if FLUSH_BUBBLE>1, loading the counter with FLUSH_BUBBLE-1. On a blocked flush_req_i, go to PEND.
  - PEND: flush_o=0. In the first cycle the block clears, assert flush_o and then proceed as in IDLE.
  - BUBBLE: assert flush_o and decrement the counter; go to IDLE when it reaches 0. A new flush_req_i reloads the counter with FLUSH_BUBBLE-1.
- For a flushed stage, flush_o has priority over stall_o; stall_o for that stage is forced to 0 while flush_o is high.
- Flushes never touch the scoreboard. Flushed stages are upstream of issue, so every issued instruction still retires.

## Timing
- Reset values: all counters 0, flush FSM in IDLE, every output 0.
- stall_o, hazard_o, sb_full_o and issue_ready_o are combinational, with zero latency from inputs and registered state.
- flush_o is combinational in the request cycle and registered for the remaining bubble cycles.
- Scoreboard updates are visible to hazard_o in the cycle after issue.
- If reset is asserted mid-flush or mid-pend, the FSM goes to IDLE and all counters clear immediately.

## Configuration
- BORUHATTI_SAYAC_EN defined:
  - stall_cyc_o increments on every cycle where stall_o[DEC_IDX] is high.
  - flush_cnt_o increments on every cycle where a flush is applied (first flush_o cycle).
  - Both counters wrap at 2^32 and reset to 0.
- BORUHATTI_SAYAC_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package boruhatti_pkg holds:
  - the flush FSM state enum (IDLE, PEND, BUBBLE);
  - the default parameter constants;
  - a register-index typedef.
- Sub-module boruhatti_skor_tablosu holds the counter array, the busy/full logic and the update logic. The top level holds stall/flush generation, the FSM and the performance counters.

## Test plan
- Reset: hold rst_i=0 with random inputs → every output is 0; after release, with no stimulus, stall_o=5'b00000.
- Stall propagation: stall_req_i=5'b01000 → stall_o=5'b01111 and issue_ready_o=0.
- RAW hazard: issue rd=5 with wr=1; next cycle issue rs1=5 → hazard_o=1, stall_o=5'b00011. Then retire rd=5 in the same cycle as the hazard → hazard_o=0 and the issue is accepted.
- Saturation (PEND_W=2): three accepted writes to rd=7 with no retire → on the fourth attempt, sb_full_o=1 and issue_ready_o=0. Retire rd=7 together with the issue → accepted, and cnt[7] stays at 3.
- Deferred flush (FLUSH_BUBBLE=2): flush_req_i pulse while stall_req_i[3]=1 for 3 cycles → flush_o=0 throughout. After release, flush_o=5'b00011 for 2 cycles.
- Counters (BORUHATTI_SAYAC_EN defined): 4 hazard cycles plus 2 flushes → stall_cyc_o=4 and flush_cnt_o=2. With the macro undefined, both read 0.
